// File: rtl/instruction_pkg.sv
// Shared instruction-level types for the fetch/decode front end.
// Holds the 32-bit instruction layout, major opcode encodings and immediate format codes.
// No logic; imported by imm_gen and imm_decode_stage.
package instruction_pkg;

    // Major opcodes (inst[6:0]) that the front end recognises.
    typedef enum logic [6:0] {
        LoadType   = 7'b0000011,
        Fence      = 7'b0001111,
        AluIType   = 7'b0010011,
        Auipc      = 7'b0010111,
        AluIWType  = 7'b0011011,
        SType      = 7'b0100011,
        RType      = 7'b0110011,
        Lui        = 7'b0110111,
        BType      = 7'b1100011,
        Jalr       = 7'b1100111,
        Jal        = 7'b1101111,
        SystemType = 7'b1110011
    } opcode_t;

    // Base 32-bit instruction layout (R-type field naming).
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        opcode_t    opcode;
    } instruction_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_format_t;

endpackage

// File: rtl/imm_decode_stage_imm_gen.sv
// imm_gen: combinational immediate classifier/extender for one 32-bit instruction.
// Latency 0 (pure combinational); no handshake, no backpressure.
// Ports: instruction_i -> immediate_o (N bits), format_o (imm_format_t), illegal_o.
// Optional feature macro: ZICSR_IMM_EN (csr*i instructions produce an IMM_Z immediate).
module imm_gen
    import instruction_pkg::*;
#(
    parameter int N = 32
) (
    input  instruction_t     instruction_i,
    output logic [N-1:0]     immediate_o,
    output imm_format_t      format_o,
    output logic             illegal_o
);

    logic [31:0] inst;
    logic [31:0] imm32;

    assign inst = instruction_i;

    always_comb begin
        imm32     = '0;
        format_o  = IMM_NONE;
        illegal_o = 1'b0;
        case (instruction_i.opcode)
            AluIType, LoadType, Jalr: begin
                imm32    = {{20{inst[31]}}, inst[31:20]};
                format_o = IMM_I;
            end
            AluIWType: begin
                // The W-form ALU ops only exist on RV64.
                if (N == 64) begin
                    imm32    = {{20{inst[31]}}, inst[31:20]};
                    format_o = IMM_I;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            SType: begin
                imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                format_o = IMM_S;
            end
            BType: begin
                imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                format_o = IMM_B;
            end
            Lui, Auipc: begin
                imm32    = {inst[31:12], 12'b0};
                format_o = IMM_U;
            end
            Jal: begin
                imm32    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                format_o = IMM_J;
            end
            SystemType: begin
`ifdef ZICSR_IMM_EN
                // csrrwi/csrrsi/csrrci carry a 5-bit unsigned immediate in the rs1 field.
                if (instruction_i.funct3[2]) begin
                    imm32    = {27'b0, instruction_i.rs1};
                    format_o = IMM_Z;
                end
`endif
            end
            RType, Fence: begin
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    // imm32 bit 31 is already the sign for every format, and zero for IMM_Z,
    // so a plain sign extension covers all cases.
    generate
        if (N == 64) begin : g_rv64
            assign immediate_o = {{32{imm32[31]}}, imm32};
        end else begin : g_rv32
            assign immediate_o = imm32;
        end
    endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate-generation stage between fetch and decode.
// Latency 1 cycle (accept at edge k -> out_valid after edge k); 1 entry/cycle when unstalled.
// Backpressure: 2-entry skid (output reg + skid reg); in_ready = !skid_valid, registered.
// Ports: clock/reset (async, active-high), flush; in_valid/in_ready/in_instruction/in_tag;
//        out_valid/out_ready/out_immediate/out_format/out_illegal/out_tag.
// Optional feature macro: ZICSR_IMM_EN (passed through to imm_gen).
module imm_decode_stage
    import instruction_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  instruction_t     in_instruction,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_immediate,
    output imm_format_t      out_format,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if (!(N == 32 || N == 64)) begin : g_bad_n
            $error("imm_decode_stage: N must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic [N-1:0]     imm;
        imm_format_t      fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t      in_entry;
    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic [N-1:0] gen_imm;
    imm_format_t gen_fmt;
    logic        gen_ill;
    logic        in_fire;
    logic        out_load;

    imm_gen #(.N(N)) u_imm_gen (
        .instruction_i (in_instruction),
        .immediate_o   (gen_imm),
        .format_o      (gen_fmt),
        .illegal_o     (gen_ill)
    );

    assign in_entry = '{imm: gen_imm, fmt: gen_fmt, ill: gen_ill, tag: in_tag};
    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    assign out_load = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Data registers keep stale contents; only the valids matter.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_load) begin
            if (skid_valid_q) begin
                // in_ready is low while skid is full, so no input can race this.
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_d = in_entry;
                end
            end
        end else if (in_fire) begin
            // Output is stalled: park the new entry behind it.
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_immediate = out_q.imm;
    assign out_format    = out_q.fmt;
    assign out_illegal   = out_q.ill;
    assign out_tag       = out_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;
    import instruction_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = 32'h0;
    logic [7:0]  in_tag = 8'h0;

    logic        r32, v32, il32;
    logic [31:0] imm32;
    logic [2:0]  f32;
    logic [7:0]  t32;
    logic        r64, v64, il64;
    logic [63:0] imm64;
    logic [2:0]  f64;
    logic [7:0]  t64;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    imm_decode_stage #(.N(32), .TAG_W(8)) dut32 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r32),
        .in_instruction(instruction_t'(in_inst)), .in_tag(in_tag),
        .out_valid(v32), .out_ready(out_ready),
        .out_immediate(imm32), .out_format(f32), .out_illegal(il32), .out_tag(t32)
    );

    imm_decode_stage #(.N(64), .TAG_W(8)) dut64 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r64),
        .in_instruction(instruction_t'(in_inst)), .in_tag(in_tag),
        .out_valid(v64), .out_ready(out_ready),
        .out_immediate(imm64), .out_format(f64), .out_illegal(il64), .out_tag(t64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } dec_t;

    typedef struct {
        dec_t       d32;
        dec_t       d64;
        logic [7:0] tag;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference decode straight from the format table.
    function automatic dec_t decode(input logic [31:0] x, input bit rv64);
        dec_t d;
        d.imm = 64'h0;
        d.fmt = 3'd0;
        d.ill = 1'b0;
        case (x[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                d.imm = {{52{x[31]}}, x[31:20]}; d.fmt = 3'd1;
            end
            7'b0011011: begin
                if (rv64) begin d.imm = {{52{x[31]}}, x[31:20]}; d.fmt = 3'd1; end
                else d.ill = 1'b1;
            end
            7'b0100011: begin d.imm = {{52{x[31]}}, x[31:25], x[11:7]}; d.fmt = 3'd2; end
            7'b1100011: begin
                d.imm = {{51{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0}; d.fmt = 3'd3;
            end
            7'b0110111, 7'b0010111: begin d.imm = {{32{x[31]}}, x[31:12], 12'b0}; d.fmt = 3'd4; end
            7'b1101111: begin
                d.imm = {{43{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0}; d.fmt = 3'd5;
            end
            7'b1110011: begin
`ifdef ZICSR_IMM_EN
                if (x[14]) begin d.imm = {59'b0, x[19:15]}; d.fmt = 3'd6; end
`endif
            end
            7'b0110011, 7'b0001111: begin end
            default: d.ill = 1'b1;
        endcase
        if (!rv64) d.imm[63:32] = 32'h0;
        return d;
    endfunction

    // Stage model: an in-order list of at most two entries in flight.
    always @(negedge clock) begin : cmp
        exp_t e;
        int   n;
        if (reset) begin
            sb.delete();
            chk("rst_vld32", {63'b0, v32}, 64'h0);
            chk("rst_rdy32", {63'b0, r32}, 64'h1);
            chk("rst_imm32", {32'b0, imm32}, 64'h0);
            chk("rst_fmt32", {61'b0, f32}, 64'h0);
            chk("rst_ill32", {63'b0, il32}, 64'h0);
            chk("rst_tag32", {56'b0, t32}, 64'h0);
            chk("rst_vld64", {63'b0, v64}, 64'h0);
            chk("rst_rdy64", {63'b0, r64}, 64'h1);
            chk("rst_imm64", imm64, 64'h0);
            chk("rst_fmt64", {61'b0, f64}, 64'h0);
            chk("rst_ill64", {63'b0, il64}, 64'h0);
            chk("rst_tag64", {56'b0, t64}, 64'h0);
        end else begin
            n = sb.size();
            chk("vld32", {63'b0, v32}, {63'b0, n > 0});
            chk("rdy32", {63'b0, r32}, {63'b0, n < 2});
            chk("vld64", {63'b0, v64}, {63'b0, n > 0});
            chk("rdy64", {63'b0, r64}, {63'b0, n < 2});
            if (n > 0) begin
                e = sb[0];
                chk("imm32", {32'b0, imm32}, e.d32.imm);
                chk("fmt32", {61'b0, f32}, {61'b0, e.d32.fmt});
                chk("ill32", {63'b0, il32}, {63'b0, e.d32.ill});
                chk("tag32", {56'b0, t32}, {56'b0, e.tag});
                chk("imm64", imm64, e.d64.imm);
                chk("fmt64", {61'b0, f64}, {61'b0, e.d64.fmt});
                chk("ill64", {63'b0, il64}, {63'b0, e.d64.ill});
                chk("tag64", {56'b0, t64}, {56'b0, e.tag});
            end
            // Advance to the state after the coming rising edge.
            if (flush) begin
                sb.delete();
            end else begin
                if (n > 0 && out_ready) void'(sb.pop_front());
                if (in_valid && n < 2) begin
                    e.d32 = decode(in_inst, 1'b0);
                    e.d64 = decode(in_inst, 1'b1);
                    e.tag = in_tag;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [7:0] tg,
                         input logic ordy, input logic fl);
        @(posedge clock);
        #1;
        in_valid  = v;
        in_inst   = ins;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [6:0]  ops [12] = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111,
                                  7'b0011011, 7'b0100011, 7'b0110011, 7'b0110111,
                                  7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011};
        logic [31:0] x;
        int          sel;
        x   = $urandom;
        sel = $urandom_range(0, 13);
        if (sel < 12) x[6:0] = ops[sel];
        else if (sel == 12) x[6:0] = 7'h7F;
        return x;
    endfunction

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;

        // addi x1,x0,-1
        drive(1, 32'hFFF00093, 8'h10, 1, 0);
        drive(0, 32'h0, 8'h0, 1, 0);
        @(negedge clock);
        chk("addi_imm32", {32'b0, imm32}, 64'h0000_0000_FFFF_FFFF);
        chk("addi_fmt32", {61'b0, f32}, 64'd1);
        chk("addi_tag32", {56'b0, t32}, 64'h10);

        // lui x1,0x80000 then jal x0,-4
        drive(1, 32'h800000B7, 8'h20, 1, 0);
        drive(1, 32'hFFDFF06F, 8'h21, 1, 0);
        @(negedge clock);
        chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui_fmt64", {61'b0, f64}, 64'd4);
        drive(0, 32'h0, 8'h0, 1, 0);
        @(negedge clock);
        chk("jal_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("jal_fmt64", {61'b0, f64}, 64'd5);

        // addiw on RV32 is illegal, legal on RV64; opcode 7F illegal everywhere
        drive(1, 32'hFFF0009B, 8'h30, 1, 0);
        drive(1, 32'h0000007F, 8'h31, 1, 0);
        @(negedge clock);
        chk("addiw_ill32", {63'b0, il32}, 64'd1);
        chk("addiw_imm32", {32'b0, imm32}, 64'd0);
        chk("addiw_ill64", {63'b0, il64}, 64'd0);
        chk("addiw_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1, 32'h3002D073, 8'h32, 1, 0);
        @(negedge clock);
        chk("op7f_ill32", {63'b0, il32}, 64'd1);
        chk("op7f_ill64", {63'b0, il64}, 64'd1);
        drive(0, 32'h0, 8'h0, 1, 0);
        @(negedge clock);
`ifdef ZICSR_IMM_EN
        chk("csrrwi_imm", {32'b0, imm32}, 64'd5);
        chk("csrrwi_fmt", {61'b0, f32}, 64'd6);
`else
        chk("csrrwi_imm", {32'b0, imm32}, 64'd0);
        chk("csrrwi_fmt", {61'b0, f32}, 64'd0);
`endif
        chk("csrrwi_ill", {63'b0, il32}, 64'd0);

        // backpressure: tags 1,2 buffered, tag 3 held off
        drive(1, 32'h00500113, 8'd1, 0, 0);
        drive(1, 32'h00500113, 8'd2, 0, 0);
        drive(1, 32'h00500113, 8'd3, 0, 0);
        @(negedge clock);
        chk("bp_rdy_full", {63'b0, r32}, 64'd0);
        chk("bp_tag_a", {56'b0, t32}, 64'd1);
        drive(1, 32'h00500113, 8'd3, 1, 0);
        @(negedge clock);
        chk("bp_tag_b", {56'b0, t32}, 64'd1);
        drive(1, 32'h00500113, 8'd3, 1, 0);
        @(negedge clock);
        chk("bp_tag_c", {56'b0, t32}, 64'd2);
        chk("bp_rdy_free", {63'b0, r32}, 64'd1);
        drive(0, 32'h0, 8'd0, 1, 0);
        @(negedge clock);
        chk("bp_tag_d", {56'b0, t32}, 64'd3);
        drive(0, 32'h0, 8'd0, 1, 0);
        @(negedge clock);
        chk("bp_empty", {63'b0, v32}, 64'd0);

        // flush with both entries buffered and input valid
        drive(1, rnd_inst(), 8'hA1, 0, 0);
        drive(1, rnd_inst(), 8'hA2, 0, 0);
        drive(1, rnd_inst(), 8'hA3, 0, 1);
        drive(0, 32'h0, 8'h0, 1, 0);
        @(negedge clock);
        chk("flush_vld", {63'b0, v32}, 64'd0);
        chk("flush_rdy", {63'b0, r32}, 64'd1);

        // random traffic with occasional flush and one mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock);
            #1;
            reset     = 1'b0;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rnd_inst();
            in_tag    = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            if (i == 1500) begin
                #2;
                reset = 1'b1;
            end
        end

        drive(0, 32'h0, 8'h0, 1, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
